// File: rtl/uart_echo_fifo_if.sv
// Pin and status bundle for uart_echo_fifo.
// master = line/host side, slave = the echo block itself.
interface uart_echo_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  logic              uart_rx_pin;
  logic              uart_tx_pin;
  logic              tx_en;
  logic              err_clr;
  logic [LevelW-1:0] fifo_level;
  logic              tx_busy;
  logic              parity_err;
  logic              frame_err;
  logic              overrun_err;

  modport master (
    output uart_rx_pin, tx_en, err_clr,
    input  uart_tx_pin, fifo_level, tx_busy, parity_err, frame_err, overrun_err
  );

  modport slave (
    input  uart_rx_pin, tx_en, err_clr,
    output uart_tx_pin, fifo_level, tx_busy, parity_err, frame_err, overrun_err
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// UART receiver feeding a byte FIFO that is echoed back out of a UART transmitter.
// RX uses a shared 16x oversample tick; TX times bits with its own per-frame counter.
module uart_echo_fifo #(
  parameter int unsigned CLK_FREQ   = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  uart_echo_fifo_if.slave pins_io
);
  localparam int unsigned DivRaw  = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int unsigned Div     = (DivRaw == 0) ? 1 : DivRaw;
  localparam int unsigned DivW    = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned BitClks = 16 * Div;
  localparam int unsigned BitW    = $clog2(BitClks);
  localparam int unsigned AddrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW  = AddrW + 1;

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

  // Oversample tick and RX synchroniser
  logic [DivW-1:0] div_q, div_d;
  logic            tick;
  logic            rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx;

  always_comb begin
    tick    = (div_q == DivW'(Div - 1));
    div_d   = tick ? '0 : div_q + 1'b1;
    rx_s1_d = pins_io.uart_rx_pin;
    rx_s2_d = rx_s1_q;
    rx      = rx_s2_q;
  end

  // RX state
  rx_state_e              rx_state_q, rx_state_d;
  logic [3:0]             rx_tick_q, rx_tick_d;
  logic [3:0]             rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_par_bad_q, rx_par_bad_d;
  logic                   rx_push_q, rx_push_d;
  logic                   rx_par_exp;
  logic                   par_evt, frm_evt, ovr_evt;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_tick_d    = rx_tick_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_push_d    = 1'b0;
    par_evt      = 1'b0;
    frm_evt      = 1'b0;
    rx_par_exp   = (PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q;
    unique case (rx_state_q)
      RxIdle: begin
        if (!rx) begin
          rx_state_d = RxStart;
          rx_tick_d  = '0;
        end
      end
      RxStart: begin
        if (tick) begin
          if (rx_tick_q == 4'd7) begin
            // Mid start bit: a high line here was a glitch, not a frame
            rx_tick_d    = '0;
            rx_bit_d     = '0;
            rx_par_bad_d = 1'b0;
            rx_state_d   = rx ? RxIdle : RxData;
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      RxData: begin
        if (tick) begin
          if (rx_tick_q == 4'd15) begin
            rx_tick_d  = '0;
            rx_shift_d = {rx, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == 4'(DATA_BITS - 1)) begin
              rx_state_d = (PARITY != 0) ? RxParity : RxStop;
            end else begin
              rx_bit_d = rx_bit_q + 4'd1;
            end
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      RxParity: begin
        if (tick) begin
          if (rx_tick_q == 4'd15) begin
            rx_tick_d  = '0;
            rx_state_d = RxStop;
            if (rx != rx_par_exp) begin
              par_evt      = 1'b1;
              rx_par_bad_d = 1'b1;
            end
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      RxStop: begin
        if (tick) begin
          if (rx_tick_q == 4'd15) begin
            rx_tick_d  = '0;
            rx_state_d = RxIdle;
            if (!rx) begin
              frm_evt = 1'b1;
            end else if (!rx_par_bad_q) begin
              rx_push_d = 1'b1;
            end
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]    count_q, count_d;
  logic [DATA_BITS-1:0] head;
  logic                 pop, push_ok, full, empty;
  tx_state_e            tx_state_q, tx_state_d;

  always_comb begin
    full     = (count_q == LevelW'(FIFO_DEPTH));
    empty    = (count_q == '0);
    head     = mem_q[rd_ptr_q];
    pop      = (tx_state_q == TxIdle) && pins_io.tx_en && !empty;
    // A pop in the same cycle frees the slot the push needs
    push_ok  = rx_push_q && (!full || pop);
    ovr_evt  = rx_push_q && full && !pop;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= rx_shift_q;
    end
  end

  // TX state
  logic [BitW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_stop_q, tx_stop_d;
  logic                 tx_pin_q, tx_pin_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_bit_end;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    tx_pin_d   = tx_pin_q;
    tx_busy_d  = tx_busy_q;
    tx_bit_end = (tx_cnt_q == BitW'(BitClks - 1));
    tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        if (pop) begin
          tx_state_d = TxStart;
          tx_shift_d = head;
          tx_par_d   = (PARITY == 1) ? ~^head : ^head;
          tx_pin_d   = 1'b0;
          tx_busy_d  = 1'b1;
        end
      end
      TxStart: begin
        if (tx_bit_end) begin
          tx_state_d = TxData;
          tx_bit_d   = '0;
          tx_pin_d   = tx_shift_q[0];
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          if (tx_bit_q == 4'(DATA_BITS - 1)) begin
            tx_stop_d = 1'b0;
            if (PARITY != 0) begin
              tx_state_d = TxParity;
              tx_pin_d   = tx_par_q;
            end else begin
              tx_state_d = TxStop;
              tx_pin_d   = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = tx_shift_q >> 1;
            tx_pin_d   = tx_shift_d[0];
          end
        end
      end
      TxParity: begin
        if (tx_bit_end) begin
          tx_state_d = TxStop;
          tx_pin_d   = 1'b1;
        end
      end
      TxStop: begin
        if (tx_bit_end) begin
          if (tx_stop_q == 1'(STOP_BITS - 1)) begin
            tx_state_d = TxIdle;
            tx_busy_d  = 1'b0;
          end else begin
            tx_stop_d = 1'b1;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // Sticky errors: a new event in the clearing cycle wins
  logic par_err_q, par_err_d, frm_err_q, frm_err_d, ovr_err_q, ovr_err_d;

  always_comb begin
    par_err_d = par_evt | (par_err_q & ~pins_io.err_clr);
    frm_err_d = frm_evt | (frm_err_q & ~pins_io.err_clr);
    ovr_err_d = ovr_evt | (ovr_err_q & ~pins_io.err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_state_q   <= RxIdle;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_bad_q <= 1'b0;
      rx_push_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tx_state_q   <= TxIdle;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_par_q     <= 1'b0;
      tx_stop_q    <= 1'b0;
      tx_pin_q     <= 1'b1;
      tx_busy_q    <= 1'b0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      ovr_err_q    <= 1'b0;
    end else begin
      div_q        <= div_d;
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_state_q   <= rx_state_d;
      rx_tick_q    <= rx_tick_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_bad_q <= rx_par_bad_d;
      rx_push_q    <= rx_push_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_par_q     <= tx_par_d;
      tx_stop_q    <= tx_stop_d;
      tx_pin_q     <= tx_pin_d;
      tx_busy_q    <= tx_busy_d;
      par_err_q    <= par_err_d;
      frm_err_q    <= frm_err_d;
      ovr_err_q    <= ovr_err_d;
    end
  end

  assign pins_io.uart_tx_pin = tx_pin_q;
  assign pins_io.tx_busy     = tx_busy_q;
  assign pins_io.fifo_level  = count_q;
  assign pins_io.parity_err  = par_err_q;
  assign pins_io.frame_err   = frm_err_q;
  assign pins_io.overrun_err = ovr_err_q;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench: an 8N1 echo instance (a) and a 7E1 instance (b), both at 64 clk per bit.
module tb_uart_echo_fifo;
  localparam int unsigned Bit = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_echo_fifo_if #(.FIFO_DEPTH(16)) if_a ();
  uart_echo_fifo_if #(.FIFO_DEPTH(16)) if_b ();

  uart_echo_fifo #(
    .CLK_FREQ(7_372_800), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .pins_io(if_a.slave)
  );

  uart_echo_fifo #(
    .CLK_FREQ(7_372_800), .BAUD_RATE(115200), .DATA_BITS(7), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .pins_io(if_b.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Low-cycle counters on each TX pin, used to prove the line stayed idle.
  int a_low = 0;
  int b_low = 0;
  always @(negedge clk) begin
    if (if_a.uart_tx_pin !== 1'b1) a_low <= a_low + 1;
    if (if_b.uart_tx_pin !== 1'b1) b_low <= b_low + 1;
  end

  // Decodes 8N1 frames from dut_a TX as {stop, data}.
  logic [8:0] tx_frames[$];
  initial begin
    logic [8:0] f;
    forever begin
      @(negedge if_a.uart_tx_pin);
      repeat (Bit / 2) @(posedge clk);
      #1;
      if (if_a.uart_tx_pin == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (Bit) @(posedge clk);
          #1;
          f[i] = if_a.uart_tx_pin;
        end
        repeat (Bit) @(posedge clk);
        #1;
        f[8] = if_a.uart_tx_pin;
        tx_frames.push_back(f);
      end
    end
  end

  task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) if_a.uart_rx_pin = bits[i];
      else          if_b.uart_rx_pin = bits[i];
      repeat (Bit) @(negedge clk);
    end
  endtask

  task automatic send_8n1(input logic [7:0] d);
    send_bits(0, {6'h0, 1'b1, d, 1'b0}, 10);
  endtask

  task automatic measure_busy(input int sel, output int len);
    int t;
    t = 0;
    len = 0;
    while (((sel == 0) ? if_a.tx_busy : if_b.tx_busy) !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    while (((sel == 0) ? if_a.tx_busy : if_b.tx_busy) === 1'b1 && len < 3000) begin
      @(negedge clk);
      len++;
    end
  endtask

  initial begin
    int len;
    int t;
    int snap;
    if_a.uart_rx_pin = 1'b1; if_a.tx_en = 1'b1; if_a.err_clr = 1'b0;
    if_b.uart_rx_pin = 1'b1; if_b.tx_en = 1'b1; if_b.err_clr = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_tx_pin", if_a.uart_tx_pin, 1);
    check_eq("rst_busy", if_a.tx_busy, 0);
    check_eq("rst_level", if_a.fifo_level, 0);
    check_eq("rst_errs", {if_a.parity_err, if_a.frame_err, if_a.overrun_err}, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 8N1 echo of 0xA5
    fork
      send_8n1(8'hA5);
      measure_busy(0, len);
    join
    check_eq("a5_busy_len", len, 640);
    repeat (100) @(negedge clk);
    check_eq("a5_nframes", tx_frames.size(), 1);
    if (tx_frames.size() > 0) check_eq("a5_frame", tx_frames.pop_front(), 9'h1A5);
    check_eq("a5_level", if_a.fifo_level, 0);

    // 7E1: wrong parity is rejected, correct parity is echoed
    snap = b_low;
    send_bits(1, {6'h0, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
    repeat (200) @(negedge clk);
    check_eq("par_err", if_b.parity_err, 1);
    check_eq("par_level", if_b.fifo_level, 0);
    check_eq("par_tx_idle", b_low - snap, 0);
    check_eq("par_frame_err", if_b.frame_err, 0);
    fork
      send_bits(1, {6'h0, 1'b1, 1'b0, 7'h41, 1'b0}, 10);
      measure_busy(1, len);
    join
    check_eq("par_ok_busy_len", len, 640);
    check_eq("par_sticky", if_b.parity_err, 1);

    // Overrun with TX held off, then in-order drain
    if_a.tx_en = 1'b0;
    for (int i = 0; i < 16; i++) send_8n1(8'(i));
    repeat (10) @(negedge clk);
    check_eq("ovr_level16", if_a.fifo_level, 16);
    check_eq("ovr_not_yet", if_a.overrun_err, 0);
    send_8n1(8'h10);
    repeat (10) @(negedge clk);
    check_eq("ovr_level_full", if_a.fifo_level, 16);
    check_eq("ovr_err", if_a.overrun_err, 1);
    if_a.tx_en = 1'b1;
    t = 0;
    while ((if_a.fifo_level != 0 || if_a.tx_busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_in_time", (t < 20000), 1);
    repeat (100) @(negedge clk);
    check_eq("drain_level", if_a.fifo_level, 0);
    check_eq("drain_nframes", tx_frames.size(), 16);
    for (int i = 0; i < 16 && tx_frames.size() > 0; i++) begin
      check_eq($sformatf("drain_byte%0d", i), tx_frames.pop_front(), 9'h100 | 9'(i));
    end

    // False start, then a good frame, then a framing error
    if_a.uart_rx_pin = 1'b0;
    repeat (20) @(negedge clk);
    if_a.uart_rx_pin = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("fs_level", if_a.fifo_level, 0);
    check_eq("fs_errs", {if_a.parity_err, if_a.frame_err}, 0);
    check_eq("fs_no_tx", tx_frames.size(), 0);
    send_8n1(8'h5A);
    repeat (700) @(negedge clk);
    check_eq("fs_after_nframes", tx_frames.size(), 1);
    if (tx_frames.size() > 0) check_eq("fs_after_frame", tx_frames.pop_front(), 9'h15A);
    send_bits(0, {7'h0, 8'h3C, 1'b0}, 9);
    if_a.uart_rx_pin = 1'b0;
    repeat (44) @(negedge clk);
    if_a.uart_rx_pin = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("frm_err", if_a.frame_err, 1);
    check_eq("frm_level", if_a.fifo_level, 0);
    check_eq("frm_no_tx", tx_frames.size(), 0);
    if_a.err_clr = 1'b1;
    @(negedge clk);
    if_a.err_clr = 1'b0;
    @(negedge clk);
    check_eq("clr_frame_err", if_a.frame_err, 0);
    check_eq("clr_overrun_err", if_a.overrun_err, 0);

    // Reset during TX data bit 3 of 0x55
    if_a.tx_en = 1'b0;
    send_8n1(8'h55);
    send_8n1(8'h33);
    repeat (50) @(negedge clk);
    check_eq("rst_pre_level", if_a.fifo_level, 2);
    if_a.tx_en = 1'b1;
    t = 0;
    while (if_a.tx_busy !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (4 * Bit + Bit / 2) @(negedge clk);
    check_eq("rst_mid_bit3", if_a.uart_tx_pin, 0);
    check_eq("rst_mid_level", if_a.fifo_level, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_pin", if_a.uart_tx_pin, 1);
    check_eq("rst_async_level", if_a.fifo_level, 0);
    check_eq("rst_async_busy", if_a.tx_busy, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    snap = a_low;
    repeat (1500) @(negedge clk);
    check_eq("post_rst_idle", a_low - snap, 0);
    check_eq("post_rst_busy", if_a.tx_busy, 0);
    check_eq("post_rst_level", if_a.fifo_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_echo_fifo.md
UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 125_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-004 SHALL have parameter PARITY, default 0, with 0=none, 1=odd, 2=even.
REQ-005 SHALL have parameter STOP_BITS, default 1, TX stop bits, legal 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, echo buffer entries, power of 2, at least 2.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port uart_rx_pin, input, 1 bit, serial RX, asynchronous to clk, idle high.
REQ-010 SHALL have port uart_tx_pin, output, 1 bit, serial TX, idle high.
REQ-011 SHALL have port tx_en, input, 1 bit; when 1, permits TX to start a new frame.
REQ-012 SHALL have port err_clr, input, 1 bit; a one-cycle pulse clears all sticky error flags.
REQ-013 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits, current count of buffered bytes.
REQ-014 SHALL have port tx_busy, output, 1 bit, high while a TX frame is in progress.
REQ-015 SHALL have ports parity_err, frame_err and overrun_err, output, 1 bit each, sticky error flags.

Function
REQ-016 SHALL generate a one-cycle 16x oversample tick every DIV = round(CLK_FREQ/(16*BAUD_RATE)) clocks; DIV is at least 1; one bit period is 16 ticks.
REQ-017 SHALL pass uart_rx_pin through a 2-flop synchroniser before any use.
REQ-018 SHALL implement RX FSM IDLE -> START -> DATA -> PARITY (only when PARITY != 0) -> STOP -> IDLE.
REQ-019 SHALL move RX from IDLE to START on a synchronised low level, then re-sample at tick 8; if the line is high there (false start), RX SHALL return to IDLE and discard the attempt.
REQ-020 SHALL sample each data, parity and stop bit at its mid-point (16 ticks after the previous sample), LSB first.
REQ-021 SHALL treat a received parity bit not matching PARITY mode (odd/even over the data bits) as a parity error: set parity_err and do not store the byte.
REQ-022 SHALL treat a stop-bit sample of 0 as a frame error: set frame_err and do not store the byte; RX checks only the first stop bit.
REQ-023 SHALL push a good byte into the FIFO in the cycle after the stop-bit sample.
REQ-024 SHALL drop the byte and set overrun_err when the FIFO is full, unless a pop occurs in the same cycle, in which case the push is accepted and the level is unchanged.
REQ-025 SHALL implement TX FSM IDLE -> START -> DATA -> PARITY (only when PARITY != 0) -> STOP -> IDLE, each bit lasting 16 ticks, with STOP lasting STOP_BITS bit periods.
REQ-026 SHALL have TX in IDLE pop the FIFO head and enter START in the same cycle when tx_en=1 and fifo_level>0; tx_en=0 SHALL NOT abort a frame in progress.
REQ-027 SHALL NOT pop when the FIFO is empty.
REQ-028 SHALL output bytes on TX in exactly the order they were received.
REQ-029 SHALL update fifo_level in the cycle after each push/pop: +1 for push only, -1 for pop only, unchanged for both.
REQ-030 SHALL drive tx_busy=1 from START entry through the end of the last stop bit.
REQ-031 SHALL clear all error flags on err_clr=1; if a new error event occurs in the same cycle as err_clr, the flag SHALL be set (set wins).

Reset
REQ-032 SHALL, while rst_n=0, immediately force uart_tx_pin=1, tx_busy=0, fifo_level=0, parity_err=0, frame_err=0, overrun_err=0.
REQ-033 SHALL, while rst_n=0, return both FSMs to IDLE, set the synchroniser flops to 1, and zero the tick counter and FIFO pointers.
REQ-034 SHALL discard any frame in progress when reset is asserted mid-operation; FIFO contents are lost.

Verification
REQ-035 SHALL be verified with CLK_FREQ=7_372_800, BAUD_RATE=115200 (DIV=4, 64 clk per bit) for all scenarios below.
REQ-036 SHALL pass test 8N1: RX frame 0xA5 with tx_en=1 -> TX emits start, 1,0,1,0,0,1,0,1, stop; tx_busy high for exactly 640 clk.
REQ-037 SHALL pass test DATA_BITS=7, PARITY=2: RX 0x41 with parity bit 1 (wrong) -> parity_err=1, fifo_level stays 0, uart_tx_pin stays 1.
REQ-038 SHALL pass test tx_en=0, FIFO_DEPTH=16: RX 17 frames 0x00..0x10 -> fifo_level=16, overrun_err=1; then tx_en=1 -> TX emits 0x00..0x0F in order, fifo_level reaches 0.
REQ-039 SHALL pass test RX low for 20 clk then high -> no push, no error, RX back in IDLE; then stop bit 0 on frame 0x3C -> frame_err=1, no push; err_clr pulse -> frame_err=0.
REQ-040 SHALL pass test rst_n low during TX data bit 3 of 0x55 -> uart_tx_pin=1 and fifo_level=0 in the same cycle; after release TX stays idle.
